// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, applies static next-PC prediction and
// queues {ins, pc, prediction} for decode; flushes and redirects on jp_wrong.
module instr_fetch #(
    parameter int          IQ_DEPTH = 8,
    parameter int          IQ_AW    = 3,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic [31:0] jp_pc,
    output logic [31:0] pc_IC,
    input  logic        ins_flag_IC,
    input  logic [31:0] ins_IC,
    output logic        ins_valid_ID,
    input  logic        ins_ready_ID,
    output logic [31:0] ins_ID,
    output logic [31:0] pc_ID,
    output logic        pred_taken_ID,
    output logic [31:0] pred_pc_ID
);

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] pred_pc;
    } iq_ent_t;

    localparam logic [IQ_AW:0] FULL_CNT = (IQ_AW + 1)'(IQ_DEPTH);

    iq_ent_t          iq [IQ_DEPTH];
    iq_ent_t          hd;
    logic [IQ_AW-1:0] head;
    logic [IQ_AW-1:0] tail;
    logic [IQ_AW:0]   count;
    logic             skip;

    logic [6:0]  opcode;
    logic        is_jal;
    logic        is_bwd;
    logic [31:0] jal_off;
    logic [31:0] br_off;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        accept;
    logic        pop;

    assign opcode  = ins_IC[6:0];
    assign is_jal  = (opcode == 7'b1101111);
    assign is_bwd  = (opcode == 7'b1100011) && ins_IC[31];
    assign jal_off = {{11{ins_IC[31]}}, ins_IC[31], ins_IC[19:12],
                      ins_IC[20], ins_IC[30:21], 1'b0};
    assign br_off  = {{19{ins_IC[31]}}, ins_IC[31], ins_IC[7],
                      ins_IC[30:25], ins_IC[11:8], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_IC + 32'd4;
        unique case (1'b1)
            is_jal: begin
                pred_taken = 1'b1;
                pred_pc    = pc_IC + jal_off;
            end
            is_bwd: begin
                pred_taken = 1'b1;
                pred_pc    = pc_IC + br_off;
            end
            default: ;
        endcase
    end

    // Full check uses the pre-pop count: no same-cycle full bypass.
    assign accept = ins_flag_IC && !skip && (count != FULL_CNT) && !jp_wrong;
    assign pop    = ins_valid_ID && ins_ready_ID && !jp_wrong;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_IC <= RESET_PC;
            skip  <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (jp_wrong) begin
                pc_IC <= jp_pc;
                skip  <= 1'b1;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                skip <= accept;
                if (accept) begin
                    pc_IC <= pred_pc;
                    tail  <= tail + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                if (accept && !pop) count <= count + 1'b1;
                else if (!accept && pop) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && accept) iq[tail] <= '{ins_IC, pc_IC, pred_taken, pred_pc};
    end

    assign hd            = iq[head];
    assign ins_valid_ID  = (count != '0);
    assign ins_ID        = hd.ins;
    assign pc_ID         = hd.pc;
    assign pred_taken_ID = hd.taken;
    assign pred_pc_ID    = hd.pred_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scenario tasks plus a randomized run, all checked
// against a queue-based reference model of the fetch stage.
module tb_instr_fetch;

    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        jp_wrong;
    logic [31:0] jp_pc;
    logic [31:0] pc_IC;
    logic        ins_flag_IC;
    logic [31:0] ins_IC;
    logic        ins_valid_ID;
    logic        ins_ready_ID;
    logic [31:0] ins_ID;
    logic [31:0] pc_ID;
    logic        pred_taken_ID;
    logic [31:0] pred_pc_ID;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.IQ_DEPTH(8), .IQ_AW(3), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .jp_wrong(jp_wrong), .jp_pc(jp_pc), .pc_IC(pc_IC),
        .ins_flag_IC(ins_flag_IC), .ins_IC(ins_IC),
        .ins_valid_ID(ins_valid_ID), .ins_ready_ID(ins_ready_ID),
        .ins_ID(ins_ID), .pc_ID(pc_ID),
        .pred_taken_ID(pred_taken_ID), .pred_pc_ID(pred_pc_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] ppc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_skip;

    function automatic void predict(input logic [31:0] ins,
                                    input logic [31:0] pc,
                                    output logic tk,
                                    output logic [31:0] npc);
        int off;
        off = 4;
        tk  = 1'b0;
        if (ins[6:0] == 7'h6F) begin
            off = ins[30:21] * 2 + ins[20] * 2048 + ins[19:12] * 4096
                  - (ins[31] ? (1 << 20) : 0);
            tk = 1'b1;
        end else if (ins[6:0] == 7'h63 && ins[31]) begin
            off = ins[11:8] * 2 + ins[30:25] * 32 + ins[7] * 2048 - 4096;
            tk = 1'b1;
        end
        npc = pc + off;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_skip = 0;
    endtask

    task automatic model_step();
        ent_t e;
        bit acc, pp;
        if (!rst) begin
            m_reset();
            return;
        end
        if (!rdy) return;
        if (jp_wrong) begin
            mq.delete();
            m_pc   = jp_pc;
            m_skip = 1;
            return;
        end
        acc = ins_flag_IC && !m_skip && (mq.size() < DEPTH);
        pp  = (mq.size() != 0) && ins_ready_ID;
        if (acc) begin
            e.ins = ins_IC;
            e.pc  = m_pc;
            predict(ins_IC, m_pc, e.tk, e.ppc);
        end
        if (pp) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(e);
            m_pc = e.ppc;
        end
        m_skip = acc;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] p);
        jp_wrong = 1'b1;
        jp_pc    = p;
        tick();
        jp_wrong = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ins_flag_IC = 1'b1;
        ins_IC = NOP;
        tick();
        tick();
        n_checks++;
        if (pc_IC !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc: got %h expected 00000000", pc_IC);
        end
        n_checks++;
        if (ins_valid_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", ins_valid_ID);
        end
        ins_flag_IC = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nop_stream();
        logic [31:0] exp_pc [5] = '{32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
        ins_ready_ID = 1'b0;
        ins_flag_IC  = 1'b1;
        ins_IC       = NOP;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (pc_IC !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL nop_pc step %0d: got %h expected %h",
                         i, pc_IC, exp_pc[i]);
            end
        end
        n_checks++;
        if (ins_valid_ID !== 1'b1 || pc_ID !== 32'h0) begin
            n_fail++;
            $display("FAIL nop_head: got valid %b pc %h expected 1 00000000",
                     ins_valid_ID, pc_ID);
        end
        ins_flag_IC = 1'b0;
    endtask

    task automatic test_prediction();
        logic [31:0] w   [3] = '{32'h0080006F, 32'hFE000EE3, 32'h00000463};
        logic [31:0] at  [3] = '{32'h10, 32'h20, 32'h30};
        logic [31:0] nx  [3] = '{32'h18, 32'h1C, 32'h34};
        logic        tk  [3] = '{1'b1, 1'b1, 1'b0};
        ins_ready_ID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            redirect(at[i]);
            ins_flag_IC = 1'b1;
            ins_IC = w[i];
            tick();
            tick();
            ins_flag_IC = 1'b0;
            n_checks++;
            if (pc_IC !== nx[i]) begin
                n_fail++;
                $display("FAIL pred_pc_IC %0d: got %h expected %h",
                         i, pc_IC, nx[i]);
            end
            n_checks++;
            if (pred_pc_ID !== nx[i] || pred_taken_ID !== tk[i]) begin
                n_fail++;
                $display("FAIL pred_head %0d: got %h/%b expected %h/%b",
                         i, pred_pc_ID, pred_taken_ID, nx[i], tk[i]);
            end
            n_checks++;
            if (pc_ID !== at[i] || ins_ID !== w[i]) begin
                n_fail++;
                $display("FAIL pred_entry %0d: got %h/%h expected %h/%h",
                         i, pc_ID, ins_ID, at[i], w[i]);
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] hold_pc;
        int k;
        redirect(32'h40);
        ins_ready_ID = 1'b0;
        ins_flag_IC  = 1'b1;
        k = 0;
        while (mq.size() < DEPTH && k < 40) begin
            ins_IC = $urandom;
            tick();
            k++;
        end
        n_checks++;
        if (mq.size() != DEPTH) begin
            n_fail++;
            $display("FAIL full_fill: got %0d entries expected %0d",
                     mq.size(), DEPTH);
        end
        hold_pc = m_pc;
        for (int i = 0; i < 4; i++) begin
            ins_IC = $urandom;
            tick();
            n_checks++;
            if (pc_IC !== hold_pc || ins_valid_ID !== 1'b1) begin
                n_fail++;
                $display("FAIL full_hold %0d: got %h/%b expected %h/1",
                         i, pc_IC, ins_valid_ID, hold_pc);
            end
        end
        ins_ready_ID = 1'b1;
        tick();
        ins_ready_ID = 1'b0;
        n_checks++;
        if (pc_IC !== hold_pc || pc_ID !== mq[0].pc) begin
            n_fail++;
            $display("FAIL full_pop: got %h/%h expected %h/%h",
                     pc_IC, pc_ID, hold_pc, mq[0].pc);
        end
        tick();
        n_checks++;
        if (pc_IC !== m_pc || mq.size() != DEPTH) begin
            n_fail++;
            $display("FAIL full_refill: got %h expected %h", pc_IC, m_pc);
        end
        ins_flag_IC  = 1'b0;
        ins_ready_ID = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (ins_valid_ID !== 1'b1 || ins_ID !== mq[0].ins ||
                pc_ID !== mq[0].pc || pred_pc_ID !== mq[0].ppc) begin
                n_fail++;
                $display("FAIL full_drain %0d: got %h@%h expected %h@%h",
                         i, ins_ID, pc_ID, mq[0].ins, mq[0].pc);
            end
            tick();
        end
        n_checks++;
        if (ins_valid_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: got %b expected 0", ins_valid_ID);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] nxt;
        int seen;
        redirect(32'h200);
        ins_ready_ID = 1'b1;
        ins_flag_IC  = 1'b1;
        ins_IC       = NOP;
        nxt  = 32'h200;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ins_valid_ID === 1'b1) begin
                n_checks++;
                if (pc_ID !== nxt) begin
                    n_fail++;
                    $display("FAIL b2b_order: got %h expected %h", pc_ID, nxt);
                end
                nxt += 32'd4;
                seen++;
            end
        end
        n_checks++;
        if (seen < 9 || mq.size() > 1) begin
            n_fail++;
            $display("FAIL b2b_rate: got %0d pops expected at least 9", seen);
        end
        ins_flag_IC = 1'b0;
    endtask

    task automatic test_mispredict();
        int k;
        redirect(32'h300);
        ins_ready_ID = 1'b0;
        ins_flag_IC  = 1'b1;
        ins_IC       = NOP;
        k = 0;
        while (mq.size() < 5 && k < 20) begin
            tick();
            k++;
        end
        jp_wrong = 1'b1;
        jp_pc    = 32'h100;
        tick();
        jp_wrong = 1'b0;
        n_checks++;
        if (ins_valid_ID !== 1'b0 || pc_IC !== 32'h100) begin
            n_fail++;
            $display("FAIL mp_flush: got %b/%h expected 0/00000100",
                     ins_valid_ID, pc_IC);
        end
        tick();
        n_checks++;
        if (ins_valid_ID !== 1'b0 || pc_IC !== 32'h100) begin
            n_fail++;
            $display("FAIL mp_skip: got %b/%h expected 0/00000100",
                     ins_valid_ID, pc_IC);
        end
        tick();
        n_checks++;
        if (ins_valid_ID !== 1'b1 || pc_ID !== 32'h100 ||
            pc_IC !== 32'h104) begin
            n_fail++;
            $display("FAIL mp_resume: got %b/%h/%h expected 1/00000100/00000104",
                     ins_valid_ID, pc_ID, pc_IC);
        end
    endtask

    task automatic test_rdy();
        ins_ready_ID = 1'b1;
        ins_flag_IC  = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pc_IC !== 32'h104 || ins_valid_ID !== 1'b1 ||
                pc_ID !== 32'h100) begin
                n_fail++;
                $display("FAIL rdy_freeze %0d: got %h/%b/%h", i,
                         pc_IC, ins_valid_ID, pc_ID);
            end
        end
        rdy = 1'b1;
        tick();
        n_checks++;
        if (ins_valid_ID !== 1'b0 || pc_IC !== 32'h104) begin
            n_fail++;
            $display("FAIL rdy_resume: got %b/%h expected 0/00000104",
                     ins_valid_ID, pc_IC);
        end
    endtask

    task automatic test_async_reset();
        ins_ready_ID = 1'b0;
        ins_flag_IC  = 1'b1;
        ins_IC       = NOP;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (pc_IC !== 32'h0 || ins_valid_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got %h/%b expected 00000000/0",
                     pc_IC, ins_valid_ID);
        end
        m_reset();
        tick();
        rst = 1'b1;
        ins_flag_IC = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 400; i++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            jp_wrong     = ($urandom_range(0, 29) == 0);
            jp_pc        = $urandom & 32'hFFFF_FFFC;
            ins_flag_IC  = ($urandom_range(0, 3) != 0);
            ins_ready_ID = $urandom_range(0, 1) == 1;
            ins_IC       = $urandom;
            sel          = $urandom_range(0, 3);
            if (sel == 0) ins_IC[6:0] = 7'h6F;
            if (sel == 1) ins_IC[6:0] = 7'h63;
            tick();
            n_checks++;
            if (pc_IC !== m_pc || ins_valid_ID !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_state %0d: got %h/%b expected %h/%b",
                         i, pc_IC, ins_valid_ID, m_pc, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (ins_ID !== mq[0].ins || pc_ID !== mq[0].pc ||
                    pred_taken_ID !== mq[0].tk ||
                    pred_pc_ID !== mq[0].ppc) begin
                    n_fail++;
                    $display("FAIL rnd_head %0d: got %h %h %b %h expected %h %h %b %h",
                             i, ins_ID, pc_ID, pred_taken_ID, pred_pc_ID,
                             mq[0].ins, mq[0].pc, mq[0].tk, mq[0].ppc);
                end
            end
        end
        jp_wrong = 1'b0;
        rdy      = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        rdy          = 1'b1;
        jp_wrong     = 1'b0;
        jp_pc        = 32'h0;
        ins_flag_IC  = 1'b0;
        ins_IC       = NOP;
        ins_ready_ID = 1'b0;
        m_reset();
        test_reset();
        test_nop_stream();
        test_prediction();
        test_full();
        test_back_to_back();
        test_mispredict();
        test_rdy();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end fetch stage, directly downstream of the instruction cache.
- Owns the fetch PC and presents it to the cache every cycle.
- Accepts returned instruction words, applies static next-PC prediction, and buffers {ins, pc, pred_taken} in a small FIFO drained by the decoder.
- Redirects and flushes on jp_wrong.

Parameters:
- IQ_DEPTH, 8, FIFO entries (power of two, >=2)
- IQ_AW, 3, log2(IQ_DEPTH), pointer width
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- rdy  in  1  global enable; when 0 all state frozen
- jp_wrong  in  1  branch mispredict from commit
- jp_pc  in  32  correct PC, valid with jp_wrong
- pc_IC  out  32  fetch PC to cache (registered)
- ins_flag_IC  in  1  cache reports instruction valid
- ins_IC  in  32  instruction word from cache
- ins_valid_ID  out  1  FIFO head valid
- ins_ready_ID  in  1  decoder takes head this cycle
- ins_ID  out  32  head instruction
- pc_ID  out  32  head PC
- pred_taken_ID  out  1  head predicted-taken flag
- pred_pc_ID  out  32  head predicted next PC

Behaviour:
- Reset (rst=0, asynchronous): pc_IC=RESET_PC; FIFO head/tail/count=0; ins_valid_ID=0; skip=0. FIFO data contents don't-care.
- rdy=0: no register changes, including FIFO pop, even if ins_ready_ID=1.
- skip flag: the cache returns a hit one cycle after seeing a PC, so a response in the cycle after any pc_IC change is stale.
  - skip is set to 1 on every pc_IC update (accept or redirect).
  - skip is cleared on the next enabled cycle.
  - While skip=1, ins_flag_IC is ignored.
  - Steady-state hit throughput is therefore 1 instruction per 2 cycles.
- Accept condition: ins_flag_IC && !skip && count<IQ_DEPTH && !jp_wrong.
- On accept:
  - Push {ins_IC, pc_IC, pred_taken, pred_pc} at the tail.
  - pc_IC <= pred_pc.
- Full FIFO: the response is dropped and pc_IC is held. The word is refetched later (cache hit). The full check uses count before any same-cycle pop; there is no full-bypass.
- Prediction (combinational on ins_IC, opcode = ins[6:0]):
  - JAL (1101111): taken; pred_pc = pc + sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - BRANCH (1100011) with ins[31]=1 (backward): taken; pred_pc = pc + sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - All others, including forward branches and JALR: not taken; pred_pc = pc+4.
  - All additions are 32-bit modulo; wrap-around is silent.
- Pop: ins_valid_ID && ins_ready_ID pops the head. ins_valid_ID = (count!=0). Outputs are the head entry read combinationally from the array.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo IQ_DEPTH.
- jp_wrong (rdy=1) has priority over everything:
  - FIFO cleared (head=tail=count=0).
  - pc_IC <= jp_pc; skip <= 1.
  - Any same-cycle ins_flag_IC and pop are discarded.
  - ins_valid_ID=0 from the next cycle.
- Reset mid-operation clears everything immediately, independent of clk.
- No X propagation on ins_valid_ID or pc_IC after reset.

Test Plan:
- Reset/idle:
  - Hold rst=0, then release.
  - Required: pc_IC=0, ins_valid_ID=0.
  - Drive ins_flag_IC=1 continuously with NOP 32'h00000013: pushes on alternate cycles, pc_IC sequence 0,4,8; ins_valid_ID rises the cycle after the first accept; pc_ID=0.
- Prediction:
  - ins_IC=32'h0080006F (jal x0,+8) at pc 0x10: pc_IC -> 0x18, pred_taken_ID=1, pred_pc_ID=0x18.
  - ins_IC=32'hFE000EE3 (beq, -4) at 0x20: pc_IC -> 0x1C.
  - Forward beq 32'h00000463 at 0x30: pc_IC -> 0x34, pred_taken=0.
- Full FIFO:
  - ins_ready_ID=0; feed until count=8.
  - Required: further ins_flag_IC ignored and pc_IC frozen at 8 entries' predicted next PC.
  - Assert ready for 1 cycle: one pop; the next valid response is accepted.
- Simultaneous push/pop:
  - ready=1 constantly with a hit stream.
  - Required: count stays <=1; order and pc_ID strictly increasing by 4.
- Mispredict:
  - With 5 entries queued, assert jp_wrong with jp_pc=0x100 while ins_flag_IC=1.
  - Required next cycle: ins_valid_ID=0, pc_IC=0x100, that response not pushed; the response in the following cycle is also ignored (skip).
- rdy/reset:
  - rdy=0 for 3 cycles with ready=1 and ins_flag_IC=1: no state change.
  - Asynchronous rst=0 mid-burst: outputs return to reset values before the next edge.
